// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: one result bit per cycle through a single 1-bit slice; define SERIAL_ALU_SLT_EN to add SLT (0111).
// Latency: done pulses WIDTH+1 cycles after the accepting start (WIDTH RUN cycles, then one DONE cycle).
// Backpressure: none; start is taken only in IDLE, and the busy output tells the requester when it will be ignored.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_ctl,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow,
   output logic             illegal
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_SUM = 2'd2;
   localparam logic [1:0] OP_XOR = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             ainv_q, ainv_d;
   logic             binv_q, binv_d;
   logic [1:0]       op_q, op_d;
   logic             arith_q, arith_d;
   logic             ill_q, ill_d;
   logic             slt_q, slt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   logic a_bit, b_bit, bit_res, c_next;

   // The single 1-bit slice, fed by the operand bit selected by the counter.
   always_comb begin
      a_bit  = a_q[cnt_q] ^ ainv_q;
      b_bit  = b_q[cnt_q] ^ binv_q;
      c_next = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
      case (op_q)
         OP_AND:  bit_res = a_bit & b_bit;
         OP_OR:   bit_res = a_bit | b_bit;
         OP_SUM:  bit_res = a_bit ^ b_bit ^ carry_q;
         default: bit_res = a_bit ^ b_bit;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      ainv_d    = ainv_q;
      binv_d    = binv_q;
      op_d      = op_q;
      arith_d   = arith_q;
      ill_d     = ill_q;
      slt_d     = slt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      cout_d    = cout_q;
      ovf_d     = ovf_q;
      illegal_d = illegal_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_RUN;
               cnt_d     = '0;
               a_d       = a_in;
               b_d       = b_in;
               ainv_d    = 1'b0;
               binv_d    = 1'b0;
               op_d      = OP_AND;
               carry_d   = 1'b0;
               arith_d   = 1'b0;
               ill_d     = 1'b0;
               slt_d     = 1'b0;
               illegal_d = 1'b0;
               cout_d    = 1'b0;
               ovf_d     = 1'b0;
               case (alu_ctl)
                  4'b0000: op_d = OP_AND;
                  4'b0001: op_d = OP_OR;
                  4'b0011: op_d = OP_XOR;
                  4'b0010: begin
                     op_d    = OP_SUM;
                     arith_d = 1'b1;
                  end
                  4'b0110: begin
                     op_d    = OP_SUM;
                     binv_d  = 1'b1;
                     carry_d = 1'b1;
                     arith_d = 1'b1;
                  end
                  4'b1100: begin
                     ainv_d = 1'b1;
                     binv_d = 1'b1;
                  end
`ifdef SERIAL_ALU_SLT_EN
                  4'b0111: begin
                     op_d    = OP_SUM;
                     binv_d  = 1'b1;
                     carry_d = 1'b1;
                     slt_d   = 1'b1;
                  end
`endif
                  default: ill_d = 1'b1;
               endcase
            end
         end

         S_RUN: begin
            result_d[cnt_q] = bit_res;
            carry_d         = c_next;
            if (cnt_q == CNT_LAST) begin
               state_d = S_DONE;
               cout_d  = arith_q & c_next;
               ovf_d   = arith_q & (carry_q ^ c_next);
               // SLT: sign of the true difference is the difference MSB corrected by overflow.
               if (slt_q) begin
                  result_d    = '0;
                  result_d[0] = bit_res ^ carry_q ^ c_next;
               end
               if (ill_q) begin
                  result_d  = '0;
                  illegal_d = 1'b1;
               end
               zero_d = (result_d == '0);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         ainv_q    <= 1'b0;
         binv_q    <= 1'b0;
         op_q      <= OP_AND;
         arith_q   <= 1'b0;
         ill_q     <= 1'b0;
         slt_q     <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         cout_q    <= 1'b0;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ainv_q    <= ainv_d;
         binv_q    <= binv_d;
         op_q      <= op_d;
         arith_q   <= arith_d;
         ill_q     <= ill_d;
         slt_q     <= slt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         cout_q    <= cout_d;
         ovf_q     <= ovf_d;
         illegal_q <= illegal_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign carry_out = cout_q;
   assign overflow  = ovf_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8; SLT expectations follow SERIAL_ALU_SLT_EN.
module tb_serial_alu_seq;

   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_XOR = 4'b0011;
   localparam logic [3:0] C_NOR = 4'b1100;
   localparam logic [3:0] C_SLT = 4'b0111;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] alu_ctl = 4'b0;
   logic [7:0] a_in = 8'h00;
   logic [7:0] b_in = 8'h00;
   logic       busy, done, zero, carry_out, overflow, illegal;
   logic [7:0] result;

   int checks = 0;
   int failures = 0;
   int lat = 0;
   int npulse = 0;

   always #5 clk = ~clk;

   serial_alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .alu_ctl   (alu_ctl),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .carry_out (carry_out),
      .overflow  (overflow),
      .illegal   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issues one operation and returns at the falling edge of the done cycle (or after the bound).
   task automatic run_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start = 1'b1; alu_ctl = c; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic chk_res(input string tag, input logic [7:0] r, input logic z,
                          input logic c, input logic o, input logic il);
      chk({tag, ".latency"}, lat, 9);
      chk({tag, ".result"}, result, r);
      chk({tag, ".zero"}, zero, z);
      chk({tag, ".carry_out"}, carry_out, c);
      chk({tag, ".overflow"}, overflow, o);
      chk({tag, ".illegal"}, illegal, il);
   endtask

   initial begin
      #2;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.result", result, 0);
      chk("rst.zero", zero, 0);
      chk("rst.carry_out", carry_out, 0);
      chk("rst.overflow", overflow, 0);
      chk("rst.illegal", illegal, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(C_ADD, 8'h7F, 8'h01);
      chk_res("add_7f_01", 8'h80, 0, 0, 1, 0);
      chk("add_7f_01.busy_in_done", busy, 1);
      @(negedge clk);
      chk("add_7f_01.done_single", done, 0);
      chk("add_7f_01.busy_idle", busy, 0);
      chk("add_7f_01.result_held", result, 8'h80);

      run_op(C_SUB, 8'h05, 8'h05);
      chk_res("sub_05_05", 8'h00, 1, 1, 0, 0);
      run_op(C_ADD, 8'hFF, 8'h01);
      chk_res("add_ff_01", 8'h00, 1, 1, 0, 0);
      run_op(C_SUB, 8'h01, 8'h02);
      chk_res("sub_01_02", 8'hFF, 0, 0, 0, 0);
      run_op(C_AND, 8'hC3, 8'h5A);
      chk_res("and_c3_5a", 8'h42, 0, 0, 0, 0);
      run_op(C_OR, 8'hC3, 8'h5A);
      chk_res("or_c3_5a", 8'hDB, 0, 0, 0, 0);
      run_op(C_NOR, 8'hF0, 8'h0C);
      chk_res("nor_f0_0c", 8'h03, 0, 0, 0, 0);
      run_op(C_XOR, 8'hAA, 8'hFF);
      chk_res("xor_aa_ff", 8'h55, 0, 0, 0, 0);

      run_op(C_SLT, 8'h80, 8'h01);
`ifdef SERIAL_ALU_SLT_EN
      chk_res("slt_80_01", 8'h01, 0, 0, 0, 0);
`else
      chk_res("slt_80_01", 8'h00, 1, 0, 0, 1);
`endif

      run_op(4'b1111, 8'h12, 8'h34);
      chk_res("illegal_f", 8'h00, 1, 0, 0, 1);
      run_op(C_ADD, 8'h01, 8'h01);
      chk_res("add_after_illegal", 8'h02, 0, 0, 0, 0);

      // start re-asserted mid-RUN with new operands must be ignored
      @(negedge clk);
      start = 1'b1; alu_ctl = C_ADD; a_in = 8'h01; b_in = 8'h02;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      @(negedge clk); lat++;
      @(negedge clk); lat++;
      start = 1'b1; a_in = 8'h10; b_in = 8'h20;
      @(negedge clk); lat++;
      @(negedge clk); lat++;
      start = 1'b0;
      while (done !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk_res("restart_ignored", 8'h03, 0, 0, 0, 0);
      npulse = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) npulse++;
      end
      chk("restart_ignored.extra_done", npulse, 0);

      // reset during bit 4 of an ADD
      @(negedge clk);
      start = 1'b1; alu_ctl = C_ADD; a_in = 8'hFF; b_in = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("midrst.busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.result", result, 0);
      chk("midrst.zero", zero, 0);
      chk("midrst.carry_out", carry_out, 0);
      chk("midrst.overflow", overflow, 0);
      chk("midrst.illegal", illegal, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      npulse = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) npulse++;
      end
      chk("midrst.no_done", npulse, 0);
      run_op(C_ADD, 8'h03, 8'h04);
      chk_res("add_after_rst", 8'h07, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port alu_ctl  input  4  operation code, captured with start.
REQ-006 SHALL have port a_in  input  WIDTH  operand A, captured with start.
REQ-007 SHALL have port b_in  input  WIDTH  operand B, captured with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 SHALL have port done  output  1  single-cycle pulse when result is valid.
REQ-010 SHALL have port result  output  WIDTH  operation result, held stable from done until the next accepted start.
REQ-011 SHALL have port zero  output  1  high when result == 0; valid with done.
REQ-012 SHALL have port carry_out  output  1  carry out of MSB for ADD/SUB; 0 otherwise.
REQ-013 SHALL have port overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
REQ-014 SHALL have port illegal  output  1  high with done when alu_ctl was unsupported.

Function
REQ-015 SHALL decode alu_ctl: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR; 1100 NOR; 0111 SLT (see REQ-031).
REQ-016 SHALL map each code to slice controls {ainvert, binvert, op, carry-in}: AND {0,0,and,0}; OR {0,0,or,0}; ADD {0,0,sum,0}; SUB {0,1,sum,1}; XOR {0,0,xor,0}; NOR {1,1,and,0}.
REQ-017 SHALL compute one result bit per cycle, LSB first, through a single 1-bit slice (invert muxes, AND, OR, XOR, full adder, 4:1 op mux).
REQ-018 SHALL hold the inter-bit carry in a 1-bit register, loaded with the decoded carry-in on start acceptance.
REQ-019 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after bit WIDTH-1, DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL accept start only in IDLE; start in RUN or DONE ignored, no re-capture of operands.
REQ-021 SHALL assert done exactly in the DONE cycle; latency start-accept-edge to done = WIDTH+1 cycles.
REQ-022 SHALL hold busy high in RUN and DONE, low in IDLE.
REQ-023 SHALL use a bit counter of ceil(log2(WIDTH)) bits, cleared on start, terminal at WIDTH-1, no wrap past terminal.
REQ-024 SHALL set carry_out to the carry register after the MSB step for ADD/SUB.
REQ-025 SHALL set overflow = carry-into-MSB XOR carry-out-of-MSB for ADD/SUB.
REQ-026 SHALL, for unsupported codes, force result to 0, zero to 1, illegal to 1, still completing in WIDTH+1 cycles.
REQ-027 SHALL clear illegal, carry_out, overflow on each accepted start.
REQ-028 SHALL accept start in the same cycle as the DONE->IDLE return only from the following cycle (IDLE), not in DONE.

Reset
REQ-029 SHALL on rst_n low immediately force state IDLE, busy 0, done 0, result 0, zero 0, carry_out 0, overflow 0, illegal 0, counter 0, carry register 0.
REQ-030 SHALL abandon any in-flight operation on reset with no done pulse; first start after release behaves normally.

Configuration
REQ-031 SHALL with SERIAL_ALU_SLT_EN defined support 0111 SLT: run as SUB, then in DONE result = {WIDTH-1 zeros, MSB-of-difference XOR overflow}; carry_out and overflow reported 0.
REQ-032 SHALL without SERIAL_ALU_SLT_EN treat 0111 as unsupported per REQ-026.

Verification
REQ-033 SHALL cover WIDTH=8 ADD a=0x7F b=0x01 -> done at cycle 9 after start, result 0x80, overflow 1, carry_out 0, zero 0.
REQ-034 SHALL cover SUB a=0x05 b=0x05 -> result 0x00, zero 1, carry_out 1, overflow 0.
REQ-035 SHALL cover NOR a=0xF0 b=0x0C -> result 0x03; XOR a=0xAA b=0xFF -> result 0x55.
REQ-036 SHALL cover SLT a=0x80 b=0x01 -> result 0x01 with macro; illegal 1, result 0x00 without macro.
REQ-037 SHALL cover start re-asserted during RUN with new operands -> ignored, original result delivered, single done pulse.
REQ-038 SHALL cover rst_n low at bit 4 of an ADD -> all outputs 0 immediately, no done; next ADD 0x03+0x04 -> 0x07.
